apb4_ram: RTL

Parametrised APB4 slave RAM and next-generation peripheral memory for the APB subsystem. Data width, depth and wait-state count are set at elaboration. Adds byte-addressed decode, byte-lane write strobes, alignment and range error responses, and a clean registered handshake with back-to-back transfer support. Sits behind the APB bridge as a scratch/config memory and as a verification target for the APB UVM environment.

---
 rtl/apb_ram_pkg.sv | 26 ++
 rtl/apb_ram_mem.sv | 37 +++
 rtl/apb4_ram.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/apb_ram_pkg.sv
// Shared types and elaboration helpers for the apb4_ram slave memory.
package apb_ram_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_t;

    localparam int unsigned MAX_WAIT = 15;
    localparam int unsigned WCNT_W   = 4;

    function automatic int unsigned lane_cnt(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Byte-offset bits inside one word; zero for an 8-bit bus.
    function automatic int unsigned lane_lsb(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/apb_ram_mem.sv
// DEPTH x DATA_W storage with per-byte-lane write enables and a combinational read port.
// Contents are deliberately not reset.
module apb_ram_mem
    import apb_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                          clk_i,
    input  logic [lane_cnt(DATA_W)-1:0]   we_i,
    input  logic [idx_width(DEPTH)-1:0]   addr_i,
    input  logic [DATA_W-1:0]             wdata_i,
    output logic [DATA_W-1:0]             rdata_o
);

    localparam int unsigned Lanes = lane_cnt(DATA_W);
    localparam int unsigned IdxW  = idx_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              in_range;

    // Guards the unused encodings when DEPTH is not a power of two.
    assign in_range = {1'b0, addr_i} < (IdxW + 1)'(DEPTH);

    always_ff @(posedge clk_i) begin
        if (in_range) begin
            for (int k = 0; k < Lanes; k++) begin
                if (we_i[k]) begin
                    mem_q[addr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = in_range ? mem_q[addr_i] : '0;

endmodule

// File: rtl/apb4_ram.sv
// APB4 slave RAM: byte-addressed decode, optional wait states, registered response.
// Byte-lane strobes are enabled by defining APB_RAM_PSTRB_EN.
module apb4_ram
    import apb_ram_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
`ifdef APB_RAM_PSTRB_EN
    input  logic [DATA_W/8-1:0]   pstrb,
`endif
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int unsigned Lanes = lane_cnt(DATA_W);
    localparam int unsigned IdxW  = idx_width(DEPTH);
    localparam int unsigned Lsb   = lane_lsb(DATA_W);

    localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(Lanes - 1);
    localparam logic [WCNT_W-1:0] WaitInit  =
        (WAIT_CYCLES == 0) ? '0 : WCNT_W'(WAIT_CYCLES - 1);

    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
        $error("apb4_ram: DATA_W must be 8, 16, 32 or 64");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("apb4_ram: DEPTH must be at least 2");
    end
    if (WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
        $error("apb4_ram: WAIT_CYCLES must be 0..15");
    end

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [Lanes-1:0]    strb_q, strb_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;

    logic                setup;
    logic [ADDR_W-1:0]   word_idx;
    logic                err_live;
    logic [Lanes-1:0]    strb_live;

    logic [IdxW-1:0]     cur_idx;
    logic                cur_write;
    logic                cur_err;
    logic [DATA_W-1:0]   cur_wdata;
    logic [Lanes-1:0]    cur_strb;

    logic [Lanes-1:0]    mem_we;
    logic [DATA_W-1:0]   mem_rdata;

    assign setup    = psel && !penable;
    assign word_idx = paddr >> Lsb;
    assign err_live = ((paddr & AlignMask) != '0) || (word_idx >= ADDR_W'(DEPTH));

`ifdef APB_RAM_PSTRB_EN
    assign strb_live = pstrb;
`else
    assign strb_live = '1;
`endif

    // With zero wait states RESP is entered on the edge that samples SETUP, so the
    // live bus must feed the memory; afterwards the latched request is used.
    always_comb begin
        if (state_q == StIdle) begin
            cur_idx   = word_idx[IdxW-1:0];
            cur_write = pwrite;
            cur_err   = err_live;
            cur_wdata = pwdata;
            cur_strb  = strb_live;
        end else begin
            cur_idx   = idx_q;
            cur_write = write_q;
            cur_err   = err_q;
            cur_wdata = wdata_q;
            cur_strb  = strb_q;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= StIdle;
            wcnt_q    <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        case (state_q)
            StIdle: begin
                if (setup) begin
                    idx_d   = cur_idx;
                    write_d = cur_write;
                    err_d   = cur_err;
                    wdata_d = cur_wdata;
                    strb_d  = cur_strb;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        wcnt_d  = WaitInit;
                    end
                end
            end
            StWait: begin
                // Master abort: drop the transfer without a response or write.
                if (!psel) begin
                    state_d = StIdle;
                    wcnt_d  = '0;
                end else if (wcnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_we    = '0;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        if (state_d == StResp) begin
            pready_d = 1'b1;
            if (cur_err) begin
                pslverr_d = 1'b1;
            end else if (cur_write) begin
                mem_we = cur_strb;
            end else begin
                prdata_d = mem_rdata;
            end
        end
    end

    apb_ram_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i   (pclk),
        .we_i    (mem_we),
        .addr_i  (cur_idx),
        .wdata_i (cur_wdata),
        .rdata_o (mem_rdata)
    );

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule
